// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter and load scoreboard for the register file's single write port.
// Optional operand forwarding outputs are enabled by defining RF_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  alu_valid,
  input  logic [AW-1:0]         alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [AW-1:0]         lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  input  logic                  dbg_valid,
  input  logic [AW-1:0]         dbg_rd,
  input  logic [XLEN-1:0]       dbg_data,
  output logic                  dbg_ready,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic [AW-1:0]         chk_ra,
  input  logic [AW-1:0]         chk_rb,
  output logic                  stall_a,
  output logic                  stall_b,
  output logic                  rf_wen,
  output logic [AW-1:0]         rf_rc,
  output logic [XLEN-1:0]       rf_dc,
  output logic [(1<<AW)-1:0]    busy_vec,
  output logic                  sb_err
`ifdef RF_BYPASS_EN
  ,
  output logic                  fwd_a_hit,
  output logic                  fwd_b_hit,
  output logic [XLEN-1:0]       fwd_a_data,
  output logic [XLEN-1:0]       fwd_b_data
`endif
);

  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned CW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0]   starve_cnt;
  logic            starved;
  logic            wb_go;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            set_en, clr_en, sb_hit;
  logic [NREG-1:0] set_mask, clr_mask, busy_d;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    dbg_ready = 1'b0;
    if (res) begin
      if (alu_valid && starved)  alu_ready = 1'b1;
      else if (lsu_valid)        lsu_ready = 1'b1;
      else if (alu_valid)        alu_ready = 1'b1;
      else if (dbg_valid)        dbg_ready = 1'b1;
    end
  end

  always_comb begin
    wb_go   = 1'b0;
    wb_rd   = '0;
    wb_data = '0;
    if (lsu_valid && lsu_ready) begin
      wb_go = 1'b1; wb_rd = lsu_rd; wb_data = lsu_data;
    end else if (alu_valid && alu_ready) begin
      wb_go = 1'b1; wb_rd = alu_rd; wb_data = alu_data;
    end else if (dbg_valid && dbg_ready) begin
      wb_go = 1'b1; wb_rd = dbg_rd; wb_data = dbg_data;
    end
  end

  // Set is applied after clear so a same-cycle issue to a returning index stays busy.
  always_comb begin
    set_en   = iss_valid && (iss_rd != '0);
    clr_en   = lsu_valid && lsu_ready && (lsu_rd != '0);
    set_mask = set_en ? (NREG'(1) << iss_rd) : '0;
    clr_mask = clr_en ? (NREG'(1) << lsu_rd) : '0;
    busy_d   = (busy_vec & ~clr_mask) | set_mask;
    sb_hit   = set_en && busy_vec[iss_rd] && !(clr_en && (lsu_rd == iss_rd));
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rf_wen     <= 1'b0;
      rf_rc      <= '0;
      rf_dc      <= '0;
      busy_vec   <= '0;
      sb_err     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rf_wen <= wb_go && (wb_rd != '0);
      if (wb_go && (wb_rd != '0)) begin
        rf_rc <= wb_rd;
        rf_dc <= wb_data;
      end
      if (alu_valid && !alu_ready)
        starve_cnt <= starved ? starve_cnt : starve_cnt + CW'(1);
      else
        starve_cnt <= '0;
      busy_vec <= busy_d;
      if (sb_hit)
        sb_err <= 1'b1;
    end
  end

  logic inflt_a, inflt_b;
  assign inflt_a = rf_wen && (rf_rc == chk_ra) && (chk_ra != '0);
  assign inflt_b = rf_wen && (rf_rc == chk_rb) && (chk_rb != '0);

`ifdef RF_BYPASS_EN
  assign fwd_a_hit  = inflt_a;
  assign fwd_b_hit  = inflt_b;
  assign fwd_a_data = rf_dc;
  assign fwd_b_data = rf_dc;
  assign stall_a    = (chk_ra != '0) && busy_vec[chk_ra];
  assign stall_b    = (chk_rb != '0) && busy_vec[chk_rb];
`else
  assign stall_a    = ((chk_ra != '0) && busy_vec[chk_ra]) || inflt_a;
  assign stall_b    = ((chk_rb != '0) && busy_vec[chk_rb]) || inflt_b;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: grant/priority table with a writeback scoreboard,
// then hand sequences for async reset, load scoreboard and in-flight hazards.
module tb_rf_wb_arbiter;

  localparam logic [1:0] G_NONE = 2'd0, G_LSU = 2'd1, G_ALU = 2'd2, G_DBG = 2'd3;

  logic        clk = 1'b0;
  logic        res;
  logic        alu_valid, lsu_valid, dbg_valid, iss_valid;
  logic [4:0]  alu_rd, lsu_rd, dbg_rd, iss_rd, chk_ra, chk_rb;
  logic [31:0] alu_data, lsu_data, dbg_data;
  logic        alu_ready, lsu_ready, dbg_ready, stall_a, stall_b, rf_wen, sb_err;
  logic [4:0]  rf_rc;
  logic [31:0] rf_dc;
  logic [31:0] busy_vec;
`ifdef RF_BYPASS_EN
  logic        fwd_a_hit, fwd_b_hit;
  logic [31:0] fwd_a_data, fwd_b_data;
`endif

  rf_wb_arbiter #(.XLEN(32), .AW(5), .STARVE_MAX(4)) dut (
    .clk(clk), .res(res),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_ra(chk_ra), .chk_rb(chk_rb),
    .stall_a(stall_a), .stall_b(stall_b),
    .rf_wen(rf_wen), .rf_rc(rf_rc), .rf_dc(rf_dc),
    .busy_vec(busy_vec), .sb_err(sb_err)
`ifdef RF_BYPASS_EN
    , .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic dv; logic [4:0] drd; logic [31:0] dd;
    logic [1:0] g;
  } vec_t;

  typedef struct {
    logic wen; logic [4:0] rc; logic [31:0] dc;
  } exp_t;

  vec_t vt[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic dv, input logic [4:0] drd, input logic [31:0] dd,
                              input logic [1:0] g);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.dv = dv; v.drd = drd; v.dd = dd;
    v.g = g;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 1'b0; lsu_valid = 1'b0; dbg_valid = 1'b0; iss_valid = 1'b0;
    alu_rd = '0; lsu_rd = '0; dbg_rd = '0; iss_rd = '0;
    alu_data = '0; lsu_data = '0; dbg_data = '0;
  endtask

  task automatic pop_check(input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL wb_queue[%0d]: got empty queue expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("wb[%0d]", idx), {rf_wen, rf_rc, rf_dc}, {e.wen, e.rc, e.dc});
    end
  endtask

  initial begin
    logic [4:0]  exp_rc;
    logic [31:0] exp_dc;
    exp_t        e;
    vec_t        v;
    logic [2:0]  got_g;

    // grant table: LSU > ALU > DBG, ALU wins after 4 lost cycles
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, G_NONE));
    vt.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, G_ALU));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, G_NONE));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, G_NONE));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 32'h1234, G_DBG));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(1, 6, 32'hA0A0, 1, 5'(10 + i), 32'h1000 + 32'(10 + i), 1, 4, 32'h44, G_LSU));
    vt.push_back(mk(1, 6, 32'hA0A0, 1, 14, 32'h100E, 1, 4, 32'h44, G_ALU));
    vt.push_back(mk(1, 6, 32'hA0A1, 1, 14, 32'h100E, 1, 4, 32'h44, G_LSU));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, G_NONE));
    vt.push_back(mk(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, G_ALU));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, G_NONE));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1, 8, 32'h88, 1, 15, 32'h2000 + 32'(i), 0, 0, 0, G_LSU));
    vt.push_back(mk(0, 0, 0, 1, 15, 32'h2003, 0, 0, 0, G_LSU));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(1, 8, 32'h88, 1, 16, 32'h3000 + 32'(i), 0, 0, 0, G_LSU));
    vt.push_back(mk(1, 8, 32'h88, 1, 16, 32'h3004, 0, 0, 0, G_ALU));
    vt.push_back(mk(1, 9, 32'h99, 0, 0, 0, 1, 4, 32'h44, G_ALU));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, G_NONE));

    // reset state, with requests present that must not be granted
    res = 1'b0;
    idle_inputs();
    chk_ra = '0; chk_rb = '0;
    alu_valid = 1'b1; lsu_valid = 1'b1; dbg_valid = 1'b1;
    #12;
    chk("reset_ready", {alu_ready, lsu_ready, dbg_ready}, 3'b000);
    chk("reset_rf", {rf_wen, rf_rc, rf_dc}, '0);
    chk("reset_sb", {busy_vec, sb_err, stall_a, stall_b}, '0);
    idle_inputs();
    #1 res = 1'b1;

    exp_rc = '0;
    exp_dc = '0;
    for (int i = 0; i < vt.size(); i++) begin
      tick();
      if (i > 0) pop_check(i - 1);
      v = vt[i];
      alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
      lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
      dbg_valid = v.dv; dbg_rd = v.drd; dbg_data = v.dd;
      #2;
      got_g = {alu_ready, lsu_ready, dbg_ready};
      chk($sformatf("grant[%0d]", i), got_g,
          (v.g == G_ALU) ? 3'b100 : (v.g == G_LSU) ? 3'b010 : (v.g == G_DBG) ? 3'b001 : 3'b000);
      e.wen = 1'b0;
      if (v.g == G_LSU && v.lrd != 0) begin e.wen = 1'b1; exp_rc = v.lrd; exp_dc = v.ld; end
      if (v.g == G_ALU && v.ard != 0) begin e.wen = 1'b1; exp_rc = v.ard; exp_dc = v.ad; end
      if (v.g == G_DBG && v.drd != 0) begin e.wen = 1'b1; exp_rc = v.drd; exp_dc = v.dd; end
      e.rc = exp_rc;
      e.dc = exp_dc;
      exp_q.push_back(e);
    end
    tick();
    pop_check(vt.size() - 1);
    idle_inputs();
    chk("table_busy", {busy_vec, sb_err}, '0);

    // asynchronous reset drops an in-flight write between edges
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h77;
    #2 chk("async_pre_ready", alu_ready, 1'b1);
    tick();
    chk("async_pre_wen", {rf_wen, rf_rc, rf_dc}, {1'b1, 5'd5, 32'h77});
    #1 res = 1'b0;
    #1 chk("async_wen_drop", {rf_wen, rf_rc, rf_dc}, '0);
    chk("async_ready_low", alu_ready, 1'b0);
    alu_valid = 1'b0;
    tick();
    res = 1'b1;

    // load issue marks busy, load return clears it
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0; chk_ra = 5'd7; chk_rb = 5'd8;
    #1 chk("iss7_busy", busy_vec, 32'h1 << 7);
    chk("iss7_stall", {stall_a, stall_b}, 2'b10);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h70;
    #1 chk("lsu7_ready", lsu_ready, 1'b1);
    tick();
    lsu_valid = 1'b0;
    chk("lsu7_clear", busy_vec, '0);
`ifdef RF_BYPASS_EN
    chk("lsu7_fwd", {stall_a, fwd_a_hit, fwd_a_data}, {1'b0, 1'b1, 32'h70});
`else
    chk("lsu7_inflight", stall_a, 1'b1);
`endif
    tick();
    chk("lsu7_stall_gone", {stall_a, stall_b}, 2'b00);

    // set wins over same-cycle clear; re-issue without clear is an error
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h90;
    #1 chk("lsu9_ready", lsu_ready, 1'b1);
    tick();
    lsu_valid = 1'b0; iss_valid = 1'b0;
    chk("setclr9", {busy_vec, sb_err}, {32'h1 << 9, 1'b0});
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    chk("reiss9_err", {busy_vec, sb_err}, {32'h1 << 9, 1'b1});

    // in-flight operand B hazard / forward
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333;
    chk_ra = 5'd0; chk_rb = 5'd3;
    #1 chk("alu3_ready", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    chk("alu3_wb", {rf_wen, rf_rc, rf_dc}, {1'b1, 5'd3, 32'h3333});
`ifdef RF_BYPASS_EN
    chk("alu3_fwd", {stall_a, stall_b, fwd_b_hit, fwd_b_data, fwd_a_hit}, {2'b00, 1'b1, 32'h3333, 1'b0});
`else
    chk("alu3_stall", {stall_a, stall_b}, 2'b01);
`endif
    tick();
    chk("alu3_after", {rf_wen, stall_b}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
